// File: rtl/seg_scan_driver_if.sv
// Bus between seg_scan_driver and its user: value load handshake plus the scan outputs.
// The slave side is the scanner; the master side supplies value_in/load.
interface seg_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value_in;
    logic                load;
    logic                ready;
    logic [3:0]          hex;
    logic [DIGITS-1:0]   digit_sel;
    logic                blank;
    logic                frame_tick;

    modport master (
        output value_in, load,
        input  ready, hex, digit_sel, blank, frame_tick
    );

    modport slave (
        input  value_in, load,
        output ready, hex, digit_sel, blank, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with dead-time and tear-free frame updates.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits above digit 0).
module seg_scan_driver #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned DEAD    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned ValW = 4 * DIGITS;

    localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntDead = CntW'(DEAD);
    localparam logic [IdxW-1:0] IdxMax  = IdxW'(DIGITS - 1);

    typedef enum logic [0:0] {StDead, StShow} slot_state_e;

    // State at cnt==0; with no dead time a slot starts directly in SHOW.
    localparam slot_state_e StSlotStart = (DEAD > 0) ? StDead : StShow;

    slot_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [ValW-1:0]      disp_q, disp_d;
    logic [ValW-1:0]      pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic                 wrap;

    logic [3:0]           hex_q, hex_d;
    logic [DIGITS-1:0]    digit_sel_q, digit_sel_d;
    logic                 blank_q, blank_d;
    logic                 ready_q, ready_d;
    logic                 frame_tick_q, frame_tick_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StSlotStart;
            cnt_q    <= '0;
            idx_q    <= '0;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    // Next-state logic
    always_comb begin
        cnt_d    = cnt_q + CntW'(1);
        idx_d    = idx_q;
        wrap     = 1'b0;
        state_d  = state_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;

        if (cnt_q == CntMax) begin
            cnt_d   = '0;
            state_d = StSlotStart;
            if (idx_q == IdxMax) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end else if (state_q == StDead && cnt_q == CntDead - 1'b1) begin
            state_d = StShow;
        end

        // Commit uses the old pend_v, so a load on the boundary edge waits a full frame.
        if (wrap && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end
        if (bus.load && !pend_v_q) begin
            pend_d   = bus.value_in;
            pend_v_d = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_nz;
`endif

    // Output logic: next values of the registered outputs, from next-state values
    always_comb begin
        hex_d        = '0;
        blank_d      = 1'b0;
        digit_sel_d  = '1;
        frame_tick_d = wrap;
        ready_d      = !pend_v_d;

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_d == IdxW'(i)) hex_d = disp_d[4*i +: 4];
        end

`ifdef LEADING_ZERO_BLANK_EN
        upper_nz = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            upper_nz = upper_nz | (|disp_d[4*i +: 4]);
            if (i > 0 && idx_d == IdxW'(i) && !upper_nz) blank_d = 1'b1;
        end
`endif

        if (state_d == StShow && !blank_d) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_d == IdxW'(i)) digit_sel_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q        <= '0;
            digit_sel_q  <= '1;
            blank_q      <= 1'b0;
            ready_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            hex_q        <= hex_d;
            digit_sel_q  <= digit_sel_d;
            blank_q      <= blank_d;
            ready_q      <= ready_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.hex        = hex_q;
    assign bus.digit_sel  = digit_sel_q;
    assign bus.blank      = blank_q;
    assign bus.ready      = ready_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DIGITS=4, CLK_DIV=8, DEAD=2), with a small
// display/pending model for the random-load free-run section.
module tb_seg_scan_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(4)) bus ();

    seg_scan_driver #(
        .DIGITS  (4),
        .CLK_DIV (8),
        .DEAD    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [3:0] HexAf [4] = '{4'hF, 4'hA, 4'h2, 4'h1};
    localparam logic [3:0] SelAll[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [3:0] Hex30 [4] = '{4'h0, 4'h3, 4'h0, 4'h0};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] SelZero[4] = '{4'hE, 4'hF, 4'hF, 4'hF};
    localparam logic       BlkZero[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [3:0] Sel30  [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    localparam logic       Blk30  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    localparam logic [3:0] SelZero[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic       BlkZero[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [3:0] Sel30  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic       Blk30  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at cnt 0 of slot s; leaves at cnt 0 of the following slot.
    task automatic check_slot(input string t, input int s, input logic [3:0] hex_e,
                              input logic [3:0] sel_e, input logic blank_e);
        check_eq($sformatf("%s_s%0d_c0_hex", t, s), bus.hex, hex_e);
        check_eq($sformatf("%s_s%0d_c0_sel", t, s), bus.digit_sel, 4'hF);
        tick(2);
        check_eq($sformatf("%s_s%0d_c2_hex", t, s), bus.hex, hex_e);
        check_eq($sformatf("%s_s%0d_c2_sel", t, s), bus.digit_sel, sel_e);
        check_eq($sformatf("%s_s%0d_c2_blank", t, s), bus.blank, blank_e);
        tick(5);
        check_eq($sformatf("%s_s%0d_c7_sel", t, s), bus.digit_sel, sel_e);
        tick(1);
    endtask

    task automatic wait_tick(input string t, output int waited);
        waited = 0;
        do begin
            tick(1);
            waited++;
        end while (!bus.frame_tick && waited < 64);
        check_eq({t, "_tick_seen"}, bus.frame_tick, 1'b1);
    endtask

    task automatic load_pulse(input logic [15:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        tick(1);
        bus.load     = 1'b0;
    endtask

    logic [15:0] m_disp, m_pend, val;
    logic        m_pv, ld, old_pv;
    int          pos, waited;

    initial begin
        bus.value_in = '0;
        bus.load     = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // 1: reset state and blank-display scan
        check_eq("t1_ready", bus.ready, 1'b1);
        check_eq("t1_hex", bus.hex, 4'h0);
        check_eq("t1_sel", bus.digit_sel, 4'hF);
        check_eq("t1_blank", bus.blank, 1'b0);
        check_eq("t1_ftick", bus.frame_tick, 1'b0);
        for (int s = 0; s < 4; s++) check_slot("t1", s, 4'h0, SelZero[s], BlkZero[s]);
        check_eq("t1_ftick32", bus.frame_tick, 1'b1);

        // 2: accepted load, shown from the next frame boundary
        load_pulse(16'h12AF);
        check_eq("t2_ready_low", bus.ready, 1'b0);
        wait_tick("t2", waited);
        check_eq("t2_wait", waited, 31);
        check_eq("t2_ready_high", bus.ready, 1'b1);
        for (int s = 0; s < 4; s++) check_slot("t2", s, HexAf[s], SelAll[s], 1'b0);
        check_eq("t2_ftick", bus.frame_tick, 1'b1);

        // 3: load while not ready is ignored
        bus.value_in = 16'h12AF;
        bus.load     = 1'b1;
        tick(1);
        check_eq("t3_ready_low", bus.ready, 1'b0);
        bus.value_in = 16'h5555;
        tick(1);
        bus.load     = 1'b0;
        check_eq("t3_ready_still_low", bus.ready, 1'b0);
        wait_tick("t3", waited);
        check_eq("t3_wait", waited, 30);
        check_eq("t3_ready_high", bus.ready, 1'b1);
        for (int s = 0; s < 4; s++) check_slot("t3", s, HexAf[s], SelAll[s], 1'b0);
        check_eq("t3_next_hex", bus.hex, 4'hF);
        check_eq("t3_next_ready", bus.ready, 1'b1);

        // 4: leading zeros
        load_pulse(16'h0030);
        wait_tick("t4", waited);
        for (int s = 0; s < 4; s++) check_slot("t4", s, Hex30[s], Sel30[s], Blk30[s]);

        // 5: reset mid-frame with a load pending
        load_pulse(16'h12AF);
        tick(18);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_ready", bus.ready, 1'b1);
        check_eq("t5_hex", bus.hex, 4'h0);
        check_eq("t5_sel", bus.digit_sel, 4'hF);
        check_eq("t5_blank", bus.blank, 1'b0);
        check_eq("t5_ftick", bus.frame_tick, 1'b0);
        tick(2);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) check_slot("t5", s, 4'h0, SelZero[s], BlkZero[s]);
        check_eq("t5_ftick32", bus.frame_tick, 1'b1);
        check_eq("t5_hex_after", bus.hex, 4'h0);
        check_eq("t5_ready_after", bus.ready, 1'b1);

        // 6: free run with random loads against a display/pending model
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
        pos    = 0;
        for (int c = 0; c < 320; c++) begin
            ld  = ($urandom_range(0, 5) == 0);
            val = 16'($urandom);
            bus.load     = ld;
            bus.value_in = val;
            old_pv = m_pv;
            pos = (pos + 1) % 32;
            if (pos == 0 && old_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
            if (ld && !old_pv) begin
                m_pend = val;
                m_pv   = 1'b1;
            end
            tick(1);
            check_eq($sformatf("t6_c%0d_ftick", c), bus.frame_tick, pos == 0);
            check_eq($sformatf("t6_c%0d_ready", c), bus.ready, !m_pv);
            if (pos % 8 == 4)
                check_eq($sformatf("t6_c%0d_hex", c), bus.hex, (m_disp >> (4 * (pos / 8))) & 16'hF);
        end
        bus.load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
